system_boton_debounce: RTL and testbench
========================================

# system_boton_debounce

Avalon-MM slave that conditions one raw push-button input, debounces it, captures press events and raises an interrupt. It is the upstream input stage for the button path: the physical key enters here, and the Nios II software polls or services the IRQ, then drives the existing output PIOs such as the left-button output port. The register map mirrors the Altera input PIO so the same driver code applies.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable samples required to accept a new level (1 ms at 50 MHz); minimum 2.
- ACTIVE_LOW, 1: 1 means the pad reads 0 when pressed (DE0-Nano KEY); the input is inverted after synchronisation.
- clk  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- button_in  in  1  raw asynchronous pad signal.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, zero-wait-state.
- irq  out  1  level interrupt, active-high.

## Operation
- Synchroniser: 2-FF chain on button_in, then optional inversion to `btn_s`, where 1 means pressed. Both flops reset to the released level.
- Debounce FSM, state register plus counter of width clog2(DEBOUNCE_CYCLES):
  - STABLE_REL: holds here while btn_s=0. On btn_s=1, clear the counter and go to WAIT_PRESS.
  - WAIT_PRESS: increment the counter while btn_s=1. If btn_s=0, return to STABLE_REL with no event. When the counter reaches DEBOUNCE_CYCLES-1 with btn_s=1, go to STABLE_PRESS, set `level`=1 and pulse `press`.
  - STABLE_PRESS and WAIT_REL: mirror image of the two states above, clearing `level`; no event is generated on release.
- Register map (word addresses):
  - 0 DATA: read {31'b0, level}; writes are ignored.
  - 1: reads 0; writes are ignored.
  - 2 IRQMASK: read/write bit 0, reset value 0.
  - 3 EDGECAPTURE: read bit 0. Writing 1 to bit 0 clears it; writing 0 has no effect.
- edge_cap: set by `press`; cleared by a write to address 3 with writedata[0]=1. If the set and the clear occur in the same cycle, set wins.
- irq = edge_cap & irqmask, combinational from registers.
- readdata is combinational from address plus the registers. Upper 31 bits are always 0. readdata does not depend on chipselect.

## Timing
- Reset values: FSM=STABLE_REL, counter=0, level=0, edge_cap=0, irqmask=0, readdata=0 at address 0, irq=0.
- A clean press is seen in `btn_s` 2 cycles after the pad changes (3 with inversion registered). `level` rises DEBOUNCE_CYCLES cycles after `btn_s` rises. edge_cap and irq rise in the same cycle as `level`.
- A bounce shorter than DEBOUNCE_CYCLES never changes `level`. Any opposite sample restarts the count from 0.
- Register writes take effect on the clock edge of the write cycle and are visible on readdata in the next cycle.
- A reset asserted mid-count returns the FSM to STABLE_REL and discards any pending event. If the pad is held pressed through reset, it is re-qualified after reset, which yields one new press event.
- Counter cannot wrap: it saturates at DEBOUNCE_CYCLES-1 because the FSM leaves the WAIT state at that value.

## Structure
- Shared package `boton_pkg`:
  - register address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGE=3.
  - FSM state enumeration (2-bit).
- Natural sub-module `boton_debounce_core`: synchroniser, FSM and counter, with outputs `level` and `press`. The top level holds the Avalon register file and the IRQ.

## Test plan
Bench uses DEBOUNCE_CYCLES=8 and ACTIVE_LOW=1.
- Reset, then read address 0, 2 and 3 -> all return 0x00000000; irq=0.
- Drive button_in 1->0 and hold -> DATA reads 1 after exactly 2+8 cycles. EDGECAPTURE reads 1. irq stays 0 because the mask is 0.
- Write IRQMASK=1, then press -> irq rises in the same cycle as `level`. Write 0x1 to address 3 -> irq=0 the next cycle. Write 0x0 to address 3 -> no change.
- Bounce: hold button_in low for 5 cycles, high for 1, low for 5, then release -> DATA stays 0 and EDGECAPTURE stays 0.
- Clear write to address 3 in the same cycle as `press` -> EDGECAPTURE reads 1.
- Assert reset 4 cycles into WAIT_PRESS, keep the pad pressed, then deassert -> DATA=0 during and after reset. DATA becomes 1 and EDGECAPTURE becomes 1 at 2+8 cycles after reset release.

Source files
------------

// File: rtl/boton_pkg.sv
// Shared definitions for the push-button debounce block.
// Holds the Avalon register word addresses and the debounce FSM state type.
package boton_pkg;

    // Avalon word addresses (Altera input-PIO compatible map)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    typedef enum logic [1:0] {
        StStableRel   = 2'd0,
        StWaitPress   = 2'd1,
        StStablePress = 2'd2,
        StWaitRel     = 2'd3
    } boton_state_e;

endpackage

// File: rtl/boton_debounce_core.sv
// Synchroniser, optional polarity inversion and debounce FSM for one button.
// Ports:
//   i_clk        system clock (rising edge)
//   i_reset      synchronous active-high reset
//   i_button_in  raw asynchronous pad
//   o_level      debounced level, 1 = pressed
//   o_press      one-cycle pulse, coincident with the edge that sets o_level
module boton_debounce_core
    import boton_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button_in,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    // The accepting edge is the one on which the counter steps to DEBOUNCE_CYCLES-1,
    // so the FSM tests for one less than that on the current count.
    localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_CYCLES - 2);
    localparam logic RelLevel = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic            r_sync1;
    logic            r_sync2;
    logic            w_btn_s;
    boton_state_e    r_state;
    boton_state_e    w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;

    // Both synchroniser stages reset to the released pad level
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= RelLevel;
            r_sync2 <= RelLevel;
        end else begin
            r_sync1 <= i_button_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // State and counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StStableRel;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; any opposite sample abandons the qualification
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StStableRel: begin
                if (w_btn_s) begin
                    w_state_next = StWaitPress;
                    w_cnt_next   = '0;
                end
            end
            StWaitPress: begin
                if (!w_btn_s) begin
                    w_state_next = StStableRel;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == CntDone) begin
                        w_state_next = StStablePress;
                    end
                end
            end
            StStablePress: begin
                if (!w_btn_s) begin
                    w_state_next = StWaitRel;
                    w_cnt_next   = '0;
                end
            end
            StWaitRel: begin
                if (w_btn_s) begin
                    w_state_next = StStablePress;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == CntDone) begin
                        w_state_next = StStableRel;
                    end
                end
            end
            default: w_state_next = StStableRel;
        endcase
    end

    // Outputs; o_press is combinational so edge capture lands on the same edge as o_level
    always_comb begin
        o_level = (r_state == StStablePress) || (r_state == StWaitRel);
        o_press = (r_state == StWaitPress) && w_btn_s && (r_cnt == CntDone);
    end

endmodule

// File: rtl/system_boton_debounce.sv
// Avalon-MM slave wrapping a debounced push-button with PIO-style registers.
// Ports:
//   i_clk, i_reset     clock and synchronous active-high reset
//   i_button_in        raw pad input
//   i_address          word address: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE
//   i_chipselect       Avalon select
//   i_write_n          active-low write strobe
//   i_writedata        write data (only bit 0 used)
//   o_readdata         zero-wait-state read data
//   o_irq              level interrupt = edge capture & mask
module system_boton_debounce
    import boton_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_button_in,
    input  logic [1:0]  i_address,
    input  logic        i_chipselect,
    input  logic        i_write_n,
    input  logic [31:0] i_writedata,
    output logic [31:0] o_readdata,
    output logic        o_irq
);

    logic w_level;
    logic w_press;
    logic w_wr;
    logic r_irqmask;
    logic r_edge_cap;
    logic w_unused;

    boton_debounce_core #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_core (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_button_in (i_button_in),
        .o_level     (w_level),
        .o_press     (w_press)
    );

    assign w_wr     = i_chipselect & ~i_write_n;
    assign w_unused = ^i_writedata[31:1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irqmask <= 1'b0;
        end else if (w_wr && (i_address == ADDR_IRQMASK)) begin
            r_irqmask <= i_writedata[0];
        end
    end

    // A press on the same edge as a clear leaves the capture set
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_edge_cap <= 1'b0;
        end else if (w_press) begin
            r_edge_cap <= 1'b1;
        end else if (w_wr && (i_address == ADDR_EDGE) && i_writedata[0]) begin
            r_edge_cap <= 1'b0;
        end
    end

    assign o_irq = r_edge_cap & r_irqmask;

    always_comb begin
        o_readdata = '0;
        case (i_address)
            ADDR_DATA:    o_readdata[0] = w_level;
            ADDR_IRQMASK: o_readdata[0] = r_irqmask;
            ADDR_EDGE:    o_readdata[0] = r_edge_cap;
            default:      o_readdata    = '0;
        endcase
    end

endmodule

// File: tb/tb_system_boton_debounce.sv
module tb_system_boton_debounce;

    logic        clk;
    logic        reset;
    logic        button_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_checks;
    int n_fail;

    system_boton_debounce #(
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_button_in  (button_in),
        .i_address    (address),
        .i_chipselect (chipselect),
        .i_write_n    (write_n),
        .i_writedata  (writedata),
        .o_readdata   (readdata),
        .o_irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // Release the pad, let it qualify, then clear any captured edge
    task automatic settle_released();
        button_in = 1'b1;
        repeat (12) tick();
        wr(2'd3, 32'h1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 00000000", d); end
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask got %h want 00000000", d); end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_edge got %h want 00000000", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    endtask

    task automatic test_press_masked();
        logic [31:0] d;
        button_in = 1'b0;
        repeat (9) tick();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL press_early got %h want 00000000", d); end
        tick();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL press_data got %h want 00000001", d); end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL press_edge got %h want 00000001", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_masked got %b want 0", irq); end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL addr1_read got %h want 00000000", d); end
        wr(2'd0, 32'h0);
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL data_write_ignored got %h want 00000001", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        settle_released();
        wr(2'd2, 32'h1);
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL mask_read got %h want 00000001", d); end
        button_in = 1'b0;
        repeat (9) tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", irq); end
        tick();
        rd(2'd0, d);
        n_checks++;
        if (irq !== 1'b1 || d !== 32'h1) begin
            n_fail++; $display("FAIL irq_with_level got irq=%b data=%h want irq=1 data=00000001", irq, d);
        end
        wr(2'd3, 32'h0);
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            n_fail++; $display("FAIL write0_edge got edge=%h irq=%b want 00000001 1", d, irq);
        end
        wr(2'd3, 32'h1);
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL clear_edge got edge=%h irq=%b want 00000000 0", d, irq);
        end
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        settle_released();
        button_in = 1'b0;
        repeat (5) tick();
        button_in = 1'b1;
        tick();
        button_in = 1'b0;
        repeat (5) tick();
        button_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd(2'd0, d);
            n_checks++;
            if (d !== 32'h0) begin n_fail++; $display("FAIL bounce_data cycle %0d got %h want 00000000", i, d); end
            tick();
        end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL bounce_edge got %h want 00000000", d); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        settle_released();
        button_in = 1'b0;
        repeat (9) tick();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL setwin_early got %h want 00000000", d); end
        wr(2'd3, 32'h1);
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL setwin_edge got %h want 00000001", d); end
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL setwin_data got %h want 00000001", d); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        settle_released();
        button_in = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        repeat (3) tick();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_during_data got %h want 00000000", d); end
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            rd(2'd0, d);
            n_checks++;
            if (d !== 32'h0) begin n_fail++; $display("FAIL rst_after_data cycle %0d got %h want 00000000", i, d); end
        end
        tick();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL rst_requal_data got %h want 00000001", d); end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL rst_requal_edge got %h want 00000001", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_mask_cleared_irq got %b want 0", irq); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        button_in  = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        test_reset();
        test_press_masked();
        test_irq();
        test_bounce();
        test_set_wins();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
